dmem_arbiter: RTL and testbench
===============================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 The block SHALL have parameter STARVE_LIMIT, default 8, meaning consecutive port-A grants while port B waits before B is forced (legal 1..255).
REQ-002 The block SHALL have port clk  input  1  rising-edge clock.
REQ-003 The block SHALL have port rst_n  input  1  synchronous active-low reset.
REQ-004 The block SHALL have ports a_req/b_req  input  1 each  transaction request; requester holds it until its gnt.
REQ-005 The block SHALL have ports a_we/b_we  input  1 each  1=write, 0=read.
REQ-006 The block SHALL have ports a_addr/b_addr  input  32 each  word address.
REQ-007 The block SHALL have ports a_wdata/b_wdata  input  32 signed each  write data.
REQ-008 The block SHALL have ports a_gnt/b_gnt  output  1 each  registered one-cycle grant.
REQ-009 The block SHALL have ports a_rvalid/b_rvalid  output  1 each  one-cycle read-data-valid strobe.
REQ-010 The block SHALL have ports a_rdata/b_rdata  output  32 signed each  registered read data.
REQ-011 The block SHALL have ports mem_address  output  32, mem_read_wire  output  1, mem_write_wire  output  1, mem_write_data  output  32 signed  data-memory drive.
REQ-012 The block SHALL have port mem_read_data  input  32 signed  data-memory read result, valid the cycle after a read edge.

Function
REQ-013 The FSM SHALL have states IDLE, ISSUE, RDWAIT; arbitration SHALL occur only in IDLE.
REQ-014 In IDLE with any req high, the block SHALL latch winner, we, addr, wdata at the clock edge and enter ISSUE.
REQ-015 Winner SHALL be A when a_req=1, unless b_req=1 and starve_cnt==STARVE_LIMIT, then B; B when only b_req=1.
REQ-016 starve_cnt (8-bit) SHALL increment on each A grant made while b_req=1, clear on any B grant or whenever b_req=0 in IDLE, and saturate at STARVE_LIMIT.
REQ-017 In ISSUE, exactly the winner's gnt SHALL be 1 and mem_* SHALL carry the latched transaction; mem_read_wire=~we, mem_write_wire=we.
REQ-018 mem_read_wire and mem_write_wire SHALL never be 1 simultaneously, and all mem_* outputs SHALL be 0 outside ISSUE.
REQ-019 From ISSUE, a write SHALL return to IDLE; a read SHALL enter RDWAIT.
REQ-020 In RDWAIT, mem_read_data SHALL be registered into the winner's rdata at the edge, with that port's rvalid=1 for the following cycle only; state returns to IDLE.
REQ-021 Latency: req sampled edge E1 -> gnt cycle after E1 -> memory access at E2 -> rvalid/rdata the cycle after E3; write throughput one per 2 cycles, read one per 3 cycles.
REQ-022 x_rdata SHALL hold its last value until that port's next read completes; the other port's rdata SHALL be unaffected.
REQ-023 Requests arriving during ISSUE/RDWAIT SHALL be ignored until IDLE; req deasserted before grant SHALL be dropped with no side effect.
REQ-024 Addresses SHALL pass unmodified (no range check, no wrap).

Reset
REQ-025 With rst_n=0 at an edge, the block SHALL enter IDLE and clear starve_cnt, gnt, rvalid, rdata, and all mem_* outputs to 0.
REQ-026 Reset mid-transaction SHALL abort it with no rvalid issued; a write whose ISSUE cycle coincides with the reset edge still reaches memory (memory has no reset).

Verification
REQ-027 Single A write addr=5, wdata=0x1234 then A read addr=5 -> a_gnt one cycle each, a_rvalid=1 with a_rdata=0x1234 three cycles after read req sampled.
REQ-028 a_req and b_req both held high continuously, STARVE_LIMIT=2 -> grant order A,A,B,A,A,B...
REQ-029 B read addr=7 (mem=0xFFFFFFFF) -> b_rdata=-1, b_rvalid pulse; a_rvalid and a_rdata unchanged.
REQ-030 rst_n low during RDWAIT -> no rvalid, all outputs 0 next cycle, state IDLE.
REQ-031 Every cycle of a random two-port stream -> mem_read_wire&mem_write_wire==0, at most one gnt high, mem_* zero outside ISSUE, memory contents match a reference model.

Source files
------------

// File: rtl/dmem_arbiter_if.sv
// Two-requester data-memory bus: A/B transaction ports plus the shared memory drive.
// slave is the arbiter's view; master is the requesters-plus-memory view.
interface dmem_arbiter_if;
  logic               a_req,   b_req;
  logic               a_we,    b_we;
  logic [31:0]        a_addr,  b_addr;
  logic signed [31:0] a_wdata, b_wdata;
  logic               a_gnt,   b_gnt;
  logic               a_rvalid, b_rvalid;
  logic signed [31:0] a_rdata, b_rdata;
  logic [31:0]        mem_address;
  logic               mem_read_wire, mem_write_wire;
  logic signed [31:0] mem_write_data;
  logic signed [31:0] mem_read_data;

  modport slave (
    input  a_req, b_req, a_we, b_we, a_addr, b_addr, a_wdata, b_wdata, mem_read_data,
    output a_gnt, b_gnt, a_rvalid, b_rvalid, a_rdata, b_rdata,
           mem_address, mem_read_wire, mem_write_wire, mem_write_data
  );

  modport master (
    output a_req, b_req, a_we, b_we, a_addr, b_addr, a_wdata, b_wdata, mem_read_data,
    input  a_gnt, b_gnt, a_rvalid, b_rvalid, a_rdata, b_rdata,
           mem_address, mem_read_wire, mem_write_wire, mem_write_data
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter: A has priority, B is forced through after
// STARVE_LIMIT consecutive A grants while it waits. One transaction in flight.
module dmem_arbiter #(
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  dmem_arbiter_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, ISSUE, RDWAIT} state_t;

  localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

  state_t             state_q, state_d;
  logic               win_b_q, win_b_d;
  logic               we_q, we_d;
  logic [31:0]        addr_q, addr_d;
  logic signed [31:0] wdata_q, wdata_d;
  logic [7:0]         starve_q, starve_d;
  logic               a_rvalid_q, a_rvalid_d, b_rvalid_q, b_rvalid_d;
  logic signed [31:0] a_rdata_q, a_rdata_d, b_rdata_q, b_rdata_d;
  logic               pick_b;
  logic               issue;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      win_b_q    <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      starve_q   <= '0;
      a_rvalid_q <= 1'b0;
      b_rvalid_q <= 1'b0;
      a_rdata_q  <= '0;
      b_rdata_q  <= '0;
    end else begin
      state_q    <= state_d;
      win_b_q    <= win_b_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      starve_q   <= starve_d;
      a_rvalid_q <= a_rvalid_d;
      b_rvalid_q <= b_rvalid_d;
      a_rdata_q  <= a_rdata_d;
      b_rdata_q  <= b_rdata_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    win_b_d    = win_b_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    starve_d   = starve_q;
    a_rvalid_d = 1'b0;
    b_rvalid_d = 1'b0;
    a_rdata_d  = a_rdata_q;
    b_rdata_d  = b_rdata_q;
    pick_b     = bus.b_req && (!bus.a_req || starve_q == LIMIT);
    case (state_q)
      IDLE: begin
        if (!bus.b_req) starve_d = '0;
        if (bus.a_req || bus.b_req) begin
          state_d = ISSUE;
          win_b_d = pick_b;
          we_d    = pick_b ? bus.b_we    : bus.a_we;
          addr_d  = pick_b ? bus.b_addr  : bus.a_addr;
          wdata_d = pick_b ? bus.b_wdata : bus.a_wdata;
          // Only A wins that leave B waiting count toward forcing B through
          if (pick_b)                                starve_d = '0;
          else if (bus.b_req && starve_q < LIMIT)    starve_d = starve_q + 8'd1;
        end
      end
      ISSUE:   state_d = we_q ? IDLE : RDWAIT;
      RDWAIT: begin
        state_d = IDLE;
        if (win_b_q) begin
          b_rvalid_d = 1'b1;
          b_rdata_d  = bus.mem_read_data;
        end else begin
          a_rvalid_d = 1'b1;
          a_rdata_d  = bus.mem_read_data;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign issue              = (state_q == ISSUE);
  assign bus.a_gnt          = issue && !win_b_q;
  assign bus.b_gnt          = issue &&  win_b_q;
  assign bus.mem_address    = issue ? addr_q : '0;
  assign bus.mem_read_wire  = issue && !we_q;
  assign bus.mem_write_wire = issue &&  we_q;
  assign bus.mem_write_data = (issue && we_q) ? wdata_q : '0;
  assign bus.a_rvalid       = a_rvalid_q;
  assign bus.b_rvalid       = b_rvalid_q;
  assign bus.a_rdata        = a_rdata_q;
  assign bus.b_rdata        = b_rdata_q;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios plus a random two-port stream,
// checked against a transaction-level memory and grant-fairness model.
module tb_dmem_arbiter;
  localparam int LIMIT = 2;

  logic clk;
  logic rst_n;
  dmem_arbiter_if bus ();

  dmem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Memory attached to the arbiter (no reset)
  logic signed [31:0] mem [logic [31:0]];
  always @(posedge clk) begin
    if (bus.mem_write_wire) mem[bus.mem_address] = bus.mem_write_data;
    if (bus.mem_read_wire)
      bus.mem_read_data <= mem.exists(bus.mem_address) ? mem[bus.mem_address] : 32'sd0;
  end

  // Reference model: memory image by grant order, read expectations, fairness count
  logic signed [31:0] ref_mem [logic [31:0]];
  bit                 mon_en = 1'b0;
  int                 a_age = -1, b_age = -1;
  logic signed [31:0] a_exp, b_exp;
  logic signed [31:0] a_last = 0, b_last = 0;
  int                 starve_m = 0;
  int                 grant_q [$];

  function automatic logic signed [31:0] ref_rd(input logic [31:0] ad);
    return ref_mem.exists(ad) ? ref_mem[ad] : 32'sd0;
  endfunction

  always @(posedge clk) begin
    #2;
    if (mon_en) begin
      check_val("rw_excl", 32'(bus.mem_read_wire & bus.mem_write_wire), 0);
      check_val("one_gnt", 32'(bus.a_gnt & bus.b_gnt), 0);
      if (!bus.a_gnt && !bus.b_gnt)
        check_val("mem_idle", {28'd0, bus.mem_read_wire, bus.mem_write_wire,
                               |bus.mem_address, |bus.mem_write_data}, 0);

      if (a_age >= 0) a_age++;
      if (b_age >= 0) b_age++;
      check_val("a_rvalid", 32'(bus.a_rvalid), 32'(a_age == 2));
      check_val("b_rvalid", 32'(bus.b_rvalid), 32'(b_age == 2));
      if (a_age == 2) begin a_last = a_exp; a_age = -1; end
      if (b_age == 2) begin b_last = b_exp; b_age = -1; end
      check_val("a_rdata", bus.a_rdata, a_last);
      check_val("b_rdata", bus.b_rdata, b_last);

      if (bus.a_gnt) begin
        grant_q.push_back(0);
        check_val("a_gnt_req", 32'(bus.a_req), 1);
        check_val("a_fair", 32'(bus.b_req && starve_m >= LIMIT), 0);
        starve_m = bus.b_req ? starve_m + 1 : 0;
        check_val("a_addr", bus.mem_address, bus.a_addr);
        check_val("a_dir", {30'd0, bus.mem_write_wire, bus.mem_read_wire}, bus.a_we ? 2 : 1);
        if (bus.a_we) begin
          check_val("a_wdata", bus.mem_write_data, bus.a_wdata);
          ref_mem[bus.a_addr] = bus.a_wdata;
        end else begin
          a_age = 0;
          a_exp = ref_rd(bus.a_addr);
        end
      end
      if (bus.b_gnt) begin
        grant_q.push_back(1);
        check_val("b_gnt_req", 32'(bus.b_req), 1);
        check_val("b_fair", 32'(bus.a_req && starve_m != LIMIT), 0);
        starve_m = 0;
        check_val("b_addr", bus.mem_address, bus.b_addr);
        check_val("b_dir", {30'd0, bus.mem_write_wire, bus.mem_read_wire}, bus.b_we ? 2 : 1);
        if (bus.b_we) begin
          check_val("b_wdata", bus.mem_write_data, bus.b_wdata);
          ref_mem[bus.b_addr] = bus.b_wdata;
        end else begin
          b_age = 0;
          b_exp = ref_rd(bus.b_addr);
        end
      end
    end
  end

  task automatic check_outputs_zero(input string tag);
    check_val({tag, "_gnt"},    {30'd0, bus.a_gnt, bus.b_gnt}, 0);
    check_val({tag, "_rvalid"}, {30'd0, bus.a_rvalid, bus.b_rvalid}, 0);
    check_val({tag, "_a_rdata"}, bus.a_rdata, 0);
    check_val({tag, "_b_rdata"}, bus.b_rdata, 0);
    check_val({tag, "_mem_ctl"}, {30'd0, bus.mem_read_wire, bus.mem_write_wire}, 0);
    check_val({tag, "_mem_addr"}, bus.mem_address, 0);
    check_val({tag, "_mem_wdata"}, bus.mem_write_data, 0);
  endtask

  task automatic drive_port(input bit p, input bit req, input bit we,
                            input logic [31:0] ad, input logic signed [31:0] wd);
    if (!p) begin bus.a_we = we; bus.a_addr = ad; bus.a_wdata = wd; bus.a_req = req; end
    else    begin bus.b_we = we; bus.b_addr = ad; bus.b_wdata = wd; bus.b_req = req; end
  endtask

  task automatic txn(input bit p, input bit we, input logic [31:0] ad, input logic signed [31:0] wd);
    int  n;
    bit  seen;
    @(negedge clk);
    drive_port(p, 1'b1, we, ad, wd);
    n = 0;
    do begin
      @(negedge clk);
      n++;
      seen = p ? bus.b_gnt : bus.a_gnt;
    end while (!seen && n < 100);
    check_val(p ? "b_gnt_wait" : "a_gnt_wait", 32'(seen), 1);
    if (!p) bus.a_req = 1'b0; else bus.b_req = 1'b0;
    if (!we) begin
      n = 0;
      do begin
        @(negedge clk);
        n++;
        seen = p ? bus.b_rvalid : bus.a_rvalid;
      end while (!seen && n < 10);
      check_val(p ? "b_rvalid_wait" : "a_rvalid_wait", 32'(seen), 1);
    end
  endtask

  task automatic port_stream(input bit p, input int count);
    for (int i = 0; i < count; i++) begin
      bit                 we;
      logic [31:0]        ad;
      logic signed [31:0] wd;
      we = 1'($urandom_range(0, 1));
      ad = ($urandom_range(0, 9) == 0) ? 32'($urandom) : 32'($urandom_range(0, 15));
      wd = 32'($urandom);
      txn(p, we, ad, wd);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish (got timeout expected completion)");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    drive_port(0, 0, 0, 0, 0);
    drive_port(1, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #2;
    check_outputs_zero("reset");
    @(negedge clk);
    rst_n  = 1'b1;
    mon_en = 1'b1;

    // Write then read back on port A
    txn(0, 1'b1, 32'd5, 32'sh1234);
    txn(0, 1'b0, 32'd5, 32'sd0);
    check_val("a_rd_1234", bus.a_rdata, 32'h1234);

    // B reads all-ones; A's read data must stay put
    txn(0, 1'b1, 32'd7, -32'sd1);
    txn(1, 1'b0, 32'd7, 32'sd0);
    check_val("b_rd_neg1", bus.b_rdata, 32'hFFFF_FFFF);
    check_val("a_rd_keep", bus.a_rdata, 32'h1234);

    // Both ports held continuously: B forced through every LIMIT A grants
    repeat (2) @(negedge clk);
    grant_q.delete();
    drive_port(0, 1'b1, 1'b1, 32'd100, 32'sh0A0A);
    drive_port(1, 1'b1, 1'b1, 32'd200, 32'sh0B0B);
    repeat (13) @(negedge clk);
    bus.a_req = 1'b0;
    bus.b_req = 1'b0;
    repeat (2) @(negedge clk);
    check_val("starve_cnt", 32'(grant_q.size() >= 6), 1);
    for (int i = 0; i < 6 && i < grant_q.size(); i++)
      check_val($sformatf("starve_order%0d", i), grant_q[i], ((i % 3) == 2) ? 1 : 0);

    // Reset during RDWAIT aborts the read
    mon_en = 1'b0;
    drive_port(0, 1'b1, 1'b0, 32'd5, 32'sd0);
    @(negedge clk);
    check_val("rst_rd_gnt", 32'(bus.a_gnt), 1);
    bus.a_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #2;
    check_outputs_zero("rst_rdwait");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #2;
    check_outputs_zero("post_rst");

    // Write whose ISSUE cycle meets the reset edge still lands in memory
    @(negedge clk);
    drive_port(0, 1'b1, 1'b1, 32'h40, 32'sh5A5A);
    @(negedge clk);
    check_val("rst_wr_gnt", 32'(bus.a_gnt), 1);
    bus.a_req = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    ref_mem[32'h40] = 32'sh5A5A;
    check_val("rst_wr_mem", mem.exists(32'h40) ? mem[32'h40] : 32'sd0, 32'h5A5A);
    a_age = -1; b_age = -1; a_last = 0; b_last = 0; starve_m = 0;
    mon_en = 1'b1;

    // Random two-port stream
    fork
      port_stream(0, 40);
      port_stream(1, 40);
    join
    repeat (4) @(negedge clk);
    mon_en = 1'b0;

    foreach (ref_mem[k])
      check_val($sformatf("mem_%h", k), mem.exists(k) ? mem[k] : 32'sd0, ref_mem[k]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
